// File: rtl/cordic_mult_sequencer.sv
// Control stage for the 8x8 approximate CORDIC multiplier: valid/ready operand intake,
// level-sensitive start handshake with timeout, one-cycle drain, valid/ready result output.
module cordic_mult_sequencer #(
  parameter int DATA_W  = 8,
  parameter int PROD_W  = 16,
  parameter int TIMEOUT = 24,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_z,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_x,
  output logic [DATA_W-1:0] mul_z,
  input  logic [PROD_W-1:0] mul_y,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_y,
  output logic              out_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
               else          state_next = IDLE;
      RUN:     if (mul_done || timeout_hit) state_next = DRAIN;
               else                         state_next = RUN;
      DRAIN:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
               else           state_next = OUT;
      default: state_next = IDLE;
    endcase
  end

  // Data registers only move in the state that owns them; mul_done outside RUN is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= {CNT_W{1'b0}};
      mul_x   <= {DATA_W{1'b0}};
      mul_z   <= {DATA_W{1'b0}};
      out_y   <= {PROD_W{1'b0}};
      out_err <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_x <= in_x;
            mul_z <= in_z;
            cnt   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          if (mul_done) begin
            out_y   <= mul_y;
            out_err <= 1'b0;
          end else if (timeout_hit) begin
            out_y   <= {PROD_W{1'b0}};
            out_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign mul_start = (state == RUN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cordic_mult_sequencer.sv
// Self-checking bench for cordic_mult_sequencer with a stub multiplier
// (done N cycles after start rises, y = {x,z}) and a latency/result reference model.
module tb_cordic_mult_sequencer;

  localparam int TIMEOUT = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_z;
  logic        mul_start;
  logic [7:0]  mul_x;
  logic [7:0]  mul_z;
  logic [15:0] mul_y;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int         stub_n = 16;
  logic       stub_never = 1'b0;
  logic [7:0] stub_cnt = 8'd0;

  always #5 clk = ~clk;

  cordic_mult_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_z(in_z),
    .mul_start(mul_start), .mul_x(mul_x), .mul_z(mul_z),
    .mul_y(mul_y), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_err(out_err), .busy(busy)
  );

  // Stub multiplier: counts cycles with start held high, clears when start drops.
  always_ff @(posedge clk) begin
    if (!mul_start) stub_cnt <= 8'd0;
    else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  end
  assign mul_done = mul_start && !stub_never && ({24'd0, stub_cnt} >= stub_n);
  assign mul_y    = {mul_x, mul_z};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the job finishes on done if it arrives before the timeout, else aborts.
  function automatic int model_latency(input int n, input logic never);
    if (!never && n < TIMEOUT) return n + 2;
    return TIMEOUT + 1;
  endfunction

  // One complete job: accept, wait for result, optional backpressure, release.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] z,
                        input int n, input logic never, input int hold);
    int         cyc;
    logic       prev_start;
    logic       stable;
    logic [15:0] exp_y;
    logic        exp_err;
    logic [15:0] y0;
    logic        e0;
    cyc = 0;
    while (!in_ready && cyc < 100) begin tick(); cyc++; end
    check({tag, "_wait_ready"}, {31'd0, in_ready}, 32'd1);
    stub_n = n; stub_never = never;
    in_valid = 1'b1; in_x = x; in_z = z; out_ready = (hold == 0);
    tick();
    in_valid = 1'b0; in_x = $urandom; in_z = $urandom;
    cyc = 0; prev_start = 1'b1; stable = 1'b1;
    while (!out_valid && cyc < 100) begin
      prev_start = mul_start;
      if (mul_x !== x || mul_z !== z) stable = 1'b0;
      tick();
      cyc++;
    end
    exp_err = never || (n >= TIMEOUT);
    exp_y   = exp_err ? 16'h0000 : {x, z};
    check({tag, "_latency"}, cyc, model_latency(n, never));
    check({tag, "_out_y"}, {16'd0, out_y}, {16'd0, exp_y});
    check({tag, "_out_err"}, {31'd0, out_err}, {31'd0, exp_err});
    check({tag, "_drain_start_low"}, {31'd0, prev_start}, 32'd0);
    check({tag, "_mulx_stable"}, {31'd0, stable}, 32'd1);
    y0 = out_y; e0 = out_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (!out_valid || in_ready || mul_start || out_y !== y0 || out_err !== e0) stable = 1'b0;
      if (i == hold - 1) out_ready = 1'b1;
      tick();
    end
    check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    if (hold == 0) tick();
    check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int cyc;
    int ready_at;
    logic [15:0] first_y;
    logic [15:0] second_y;
    logic        saw_valid;

    // Reset with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; in_x = 8'hAA; in_z = 8'h55; out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_outs", {29'd0, out_valid, mul_start, busy}, 32'd0);
    check("reset_data", {7'd0, out_err, out_y, mul_x}, 32'd0);
    in_valid = 1'b0; rst_n = 1'b1;
    tick();

    run_op("single", 8'h12, 8'h34, 16, 1'b0, 0);
    run_op("backpressure", 8'hC3, 8'h5A, 16, 1'b0, 10);
    run_op("timeout", 8'h77, 8'h88, 16, 1'b1, 2);
    run_op("edge_n23", 8'h80, 8'h01, 23, 1'b0, 1);
    run_op("edge_n24", 8'h7F, 8'hFE, 24, 1'b0, 1);

    // Back-to-back with in_valid held high
    stub_n = 16; stub_never = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_x = 8'h81; in_z = 8'h7F;
    tick();
    in_x = 8'hFF; in_z = 8'h01;
    cyc = 0; ready_at = -1; first_y = 16'h0; second_y = 16'h0; saw_valid = 1'b0;
    while (cyc < 60 && second_y == 16'h0) begin
      if (ready_at < 0 && in_ready) ready_at = cyc;
      if (out_valid && !saw_valid) begin first_y = out_y; saw_valid = 1'b1; end
      else if (out_valid && ready_at >= 0) second_y = out_y;
      if (ready_at >= 0 && cyc == ready_at + 1) check("b2b_mulx_second", {24'd0, mul_x}, 32'h0000_00FF);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_ready_gap", ready_at, 19);
    check("b2b_first_y", {16'd0, first_y}, 32'h0000_817F);
    check("b2b_second_y", {16'd0, second_y}, 32'h0000_FF01);
    tick();
    tick();

    // Reset in the middle of RUN
    stub_n = 16;
    cyc = 0;
    while (!in_ready && cyc < 100) begin tick(); cyc++; end
    in_valid = 1'b1; in_x = 8'h3C; in_z = 8'hC3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("midrun_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset_state", {28'd0, in_ready, mul_start, busy, out_valid}, 32'd8);
    saw_valid = 1'b0;
    repeat (25) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check("midrun_no_valid", {31'd0, saw_valid}, 32'd0);
    run_op("after_reset", 8'h5E, 8'hA1, 16, 1'b0, 0);

    // Randomized jobs against the reference model
    for (int k = 0; k < 10; k++) begin
      run_op($sformatf("rand%0d", k), 8'($urandom), 8'($urandom),
             int'($urandom_range(1, 30)), 1'b0, int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
